crc3_frame_scheduler: RTL and testbench

//  Sequencer and arbiter for the serial CRC-3 encoder (poly x^3+x+1, 5-bit message, 8-bit codeword).
//  - Arbitrates NUM_REQ requesters, each offering a parallel 5-bit message.
//  - Serialises the granted message into the encoder's enable/serial-bit inputs and captures the codeword.
//  - Returns {msg,crc} with requester ID over a valid/ready response port.
//  - Cross-checks every codeword against an internal reference CRC.

---
 rtl/crc3_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/crc3_frame_scheduler.sv | 102 ++++++++++
 tb/tb_crc3_frame_scheduler.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crc3_pkg.sv
// crc3_pkg: shared widths, FSM states and the reference CRC-3 (x^3+x+1) for the frame scheduler.
package crc3_pkg;
  localparam int MSG_W = 5;
  localparam int CRC_W = 3;
  localparam int CW_W = 8;
  localparam int SHIFT_CYC = 8;
  typedef enum logic [1:0] {IDLE, SHIFT, CAPTURE, RESP} state_e;
  // Bit-serial model of the encoder: message MSB first, then CRC_W zero bits.
  function automatic logic [CRC_W-1:0] crc3_calc(input logic [MSG_W-1:0] msg);
    logic [CRC_W-1:0] c;
    logic [CW_W-1:0] bits;
    c = '0;
    bits = {msg, {CRC_W{1'b0}}};
    for (int i = CW_W - 1; i >= 0; i--) c = {bits[i] ^ c[2] ^ c[0], c[2], c[1]};
    return c;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin pick of the first request at or after ptr_i, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    idx_o,
  output logic               any_o
);
  localparam int IW = $clog2(NUM_REQ);
  logic [IW-1:0] j;
  logic hit;
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    hit = 1'b0;
    j = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = IW'((int'(ptr_i) + i) % NUM_REQ);
      if (!hit && req_i[j]) begin
        gnt_o[j] = 1'b1;
        idx_o = ID_W'(j);
        hit = 1'b1;
      end
    end
    any_o = hit;
  end
endmodule

// File: rtl/crc3_frame_scheduler.sv
// crc3_frame_scheduler: arbitrates requesters, serialises the granted message into the CRC-3
// encoder, captures and cross-checks the codeword and returns it over a valid/ready port.
module crc3_frame_scheduler
  import crc3_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [MSG_W*NUM_REQ-1:0] req_msg,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     crc_enable,
  output logic                     crc_data,
  input  logic [CW_W-1:0]          crc_cw,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [ID_W-1:0]          resp_id,
  output logic [CW_W-1:0]          resp_cw,
  output logic                     err_mismatch,
  input  logic                     err_clr,
  output logic                     busy
);
  state_e state_q, state_d;
  logic [2:0] k_q, k_d;
  logic [MSG_W-1:0] msg_q, msg_d, msg_sel;
  logic [ID_W-1:0] id_q, id_d, rr_q, rr_d, gidx;
  logic [CW_W-1:0] cw_q, cw_d;
  logic err_q, err_d, gany, mis;
  logic [NUM_REQ-1:0] gnt;
  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req_i(req_valid),
    .ptr_i(rr_q),
    .gnt_o(gnt),
    .idx_o(gidx),
    .any_o(gany)
  );
  always_comb begin
    msg_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) if (gnt[i]) msg_sel = req_msg[i*MSG_W +: MSG_W];
  end
  // Both the echoed message and the CRC field must match what was sent.
  assign mis = (state_q == CAPTURE) && (crc_cw != {msg_q, crc3_calc(msg_q)});
  always_comb begin
    state_d = state_q;
    k_d = k_q;
    msg_d = msg_q;
    id_d = id_q;
    rr_d = rr_q;
    cw_d = cw_q;
    err_d = mis | (err_q & ~err_clr);
    case (state_q)
      IDLE: if (gany) begin
        state_d = SHIFT;
        msg_d = msg_sel;
        id_d = gidx;
        rr_d = (gidx == ID_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
        k_d = '0;
      end
      SHIFT: begin
        k_d = k_q + 1'b1;
        state_d = (k_q == 3'(SHIFT_CYC - 1)) ? CAPTURE : SHIFT;
      end
      CAPTURE: begin
        cw_d = crc_cw;
        state_d = RESP;
      end
      RESP: state_d = resp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q <= '0;
      msg_q <= '0;
      id_q <= '0;
      rr_q <= '0;
      cw_q <= '0;
      err_q <= 1'b0;
    end else if (ena) begin
      state_q <= state_d;
      k_q <= k_d;
      msg_q <= msg_d;
      id_q <= id_d;
      rr_q <= rr_d;
      cw_q <= cw_d;
      err_q <= err_d;
    end
  end
  assign req_ready = (rst_n && ena && state_q == IDLE) ? gnt : '0;
  // CAPTURE keeps the encoder enabled so its registered result is still valid when sampled.
  assign crc_enable = (state_q == SHIFT) || (state_q == CAPTURE);
  assign crc_data = (state_q == SHIFT && k_q < 3'(MSG_W)) ? msg_q[3'(MSG_W - 1) - k_q] : 1'b0;
  assign resp_valid = (state_q == RESP);
  assign resp_id = id_q;
  assign resp_cw = cw_q;
  assign err_mismatch = err_q;
  assign busy = (state_q != IDLE);
endmodule

// File: tb/tb_crc3_frame_scheduler.sv
// tb_crc3_frame_scheduler: scheduler driving a behavioural serial CRC-3 encoder, with a
// response scoreboard and per-scenario checks.
module tb_crc3_frame_scheduler;
  localparam int N = 4;
  typedef struct packed {
    logic [1:0] id;
    logic [7:0] cw;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0, ena = 1'b1, resp_ready = 1'b0, err_clr = 1'b0;
  logic [N-1:0] req_valid = '0;
  logic [5*N-1:0] req_msg = '0;
  logic [N-1:0] req_ready;
  logic crc_enable, crc_data, resp_valid, err_mismatch, busy;
  logic [7:0] crc_cw, resp_cw;
  logic [1:0] resp_id;
  logic [4:0] e_msg;
  logic [2:0] e_c;
  logic [3:0] e_n;
  logic [2:0] corrupt = '0;
  int n_chk = 0, n_pass = 0, cyc = 0;
  exp_t sbq[$];
  int gq[$];
  int gt[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  crc3_frame_scheduler #(.NUM_REQ(N), .ID_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .req_valid(req_valid), .req_msg(req_msg),
    .req_ready(req_ready), .crc_enable(crc_enable), .crc_data(crc_data), .crc_cw(crc_cw),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_cw(resp_cw),
    .err_mismatch(err_mismatch), .err_clr(err_clr), .busy(busy)
  );

  // Serial encoder: clears while disabled, absorbs 8 bits, then holds while enabled.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_msg <= '0; e_c <= '0; e_n <= '0;
    end else if (ena) begin
      if (!crc_enable) begin
        e_msg <= '0; e_c <= '0; e_n <= '0;
      end else if (e_n < 8) begin
        if (e_n < 5) e_msg <= {e_msg[3:0], crc_data};
        e_c <= {crc_data ^ e_c[2] ^ e_c[0], e_c[2], e_c[1]};
        e_n <= e_n + 1'b1;
      end
    end
  end
  assign crc_cw = {e_msg, e_c ^ corrupt};

  function automatic logic [7:0] exp_cw(input logic [4:0] m);
    logic [2:0] c;
    logic [7:0] s;
    c = '0;
    s = {m, 3'b000};
    for (int i = 0; i < 8; i++) begin
      c = {s[7] ^ c[2] ^ c[0], c[2], c[1]};
      s = s << 1;
    end
    return {m, c};
  endfunction

  always @(negedge clk) begin
    exp_t e;
    #2;
    if (rst_n && ena && |req_ready) begin
      n_chk++;
      if ($onehot(req_ready)) n_pass++;
      else $display("FAIL grant_onehot req_ready=%b required one-hot", req_ready);
      for (int i = 0; i < N; i++) if (req_ready[i]) begin gq.push_back(i); gt.push_back(cyc); end
    end
    if (rst_n && ena && resp_valid && resp_ready) begin
      n_chk++;
      if (sbq.size() == 0) $display("FAIL unexpected_resp got id=%0d cw=%h required no response", resp_id, resp_cw);
      else begin
        e = sbq.pop_front();
        if (resp_id === e.id && resp_cw === e.cw) n_pass++;
        else $display("FAIL resp got id=%0d cw=%h required id=%0d cw=%h", resp_id, resp_cw, e.id, e.cw);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout after %0d cycles", cyc);
    $fatal(1);
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic wait_grant(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      #1;
      if (|req_ready) begin ok = 1'b1; break; end
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_drain(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      if (sbq.size() == 0 && !busy) begin ok = 1'b1; break; end
      step();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 4'hF;
    step();
    n_chk++;
    if ({req_ready, crc_enable, crc_data, resp_valid, resp_id, resp_cw, err_mismatch, busy} === '0) n_pass++;
    else $display("FAIL reset_outputs got rr=%b en=%b d=%b rv=%b id=%0d cw=%h err=%b busy=%b required all 0",
                  req_ready, crc_enable, crc_data, resp_valid, resp_id, resp_cw, err_mismatch, busy);
    req_valid = '0;
    rst_n = 1'b1;
    step();
    n_chk++;
    if ({req_ready, busy, crc_enable} === '0) n_pass++;
    else $display("FAIL idle_after_reset got rr=%b busy=%b en=%b required 0", req_ready, busy, crc_enable);
  endtask

  task automatic test_single();
    int first, en;
    logic [7:0] ser;
    first = -1; en = 0; ser = '0;
    req_msg[4:0] = 5'b10110;
    req_valid = 4'b0001;
    resp_ready = 1'b1;
    sbq.push_back({2'd0, 8'hB3});
    #1;
    n_chk++;
    if (req_ready === 4'b0001) n_pass++;
    else $display("FAIL single_ready got %b required 0001", req_ready);
    step();
    req_valid = '0;
    n_chk++;
    if ({req_ready, busy, crc_enable} === 6'b000011) n_pass++;
    else $display("FAIL single_pulse got rr=%b busy=%b en=%b required 0000 1 1", req_ready, busy, crc_enable);
    for (int i = 0; i < 20; i++) begin
      if (crc_enable) en++;
      if (resp_valid && first < 0) first = i;
      if (i < 8) ser[7-i] = crc_data;
      step();
    end
    n_chk++;
    if (first == 9) n_pass++; else $display("FAIL single_latency got %0d required 9", first);
    n_chk++;
    if (en == 9) n_pass++; else $display("FAIL single_enable_cycles got %0d required 9", en);
    n_chk++;
    if (ser === 8'b10110000) n_pass++; else $display("FAIL single_serial got %b required 10110000", ser);
    n_chk++;
    if (err_mismatch === 1'b0 && sbq.size() == 0) n_pass++;
    else $display("FAIL single_done got err=%b pending=%0d required 0 0", err_mismatch, sbq.size());
  endtask

  task automatic test_req2();
    bit ok;
    int low;
    low = 0;
    req_msg[14:10] = 5'b00000;
    req_valid = 4'b0100;
    sbq.push_back({2'd2, 8'h00});
    wait_grant(20, ok);
    n_chk++;
    if (ok && req_ready === 4'b0100) n_pass++; else $display("FAIL req2_grant1 got %b required 0100", req_ready);
    step();
    req_msg[14:10] = 5'b00001;
    sbq.push_back({2'd2, 8'h0B});
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!crc_enable) low++;
      if (|req_ready) begin ok = 1'b1; break; end
      step();
    end
    n_chk++;
    if (ok && req_ready === 4'b0100 && low == 2) n_pass++;
    else $display("FAIL req2_gap got rr=%b low=%0d required 0100 low=2", req_ready, low);
    step();
    req_valid = '0;
    wait_drain(40, ok);
    n_chk++;
    if (ok) n_pass++; else $display("FAIL req2_drain got pending=%0d required 0", sbq.size());
  endtask

  task automatic test_rotation();
    bit ok;
    logic [4:0] m;
    do_reset();
    gq.delete();
    gt.delete();
    for (int i = 0; i < N; i++) req_msg[5*i +: 5] = 5'(7 * i + 3);
    for (int k = 0; k < 5; k++) begin
      m = 5'(7 * (k % N) + 3);
      sbq.push_back({2'(k % N), exp_cw(m)});
    end
    resp_ready = 1'b1;
    req_valid = 4'hF;
    for (int t = 0; t < 80 && gq.size() < 5; t++) step();
    req_valid = '0;
    n_chk++;
    if (gq.size() == 5) n_pass++; else $display("FAIL rot_count got %0d required 5", gq.size());
    for (int k = 0; k < 5; k++) if (gq.size() > k) begin
      n_chk++;
      if (gq[k] == k % N) n_pass++; else $display("FAIL rot_order[%0d] got %0d required %0d", k, gq[k], k % N);
    end
    for (int k = 0; k < 4; k++) if (gt.size() > k + 1) begin
      n_chk++;
      if (gt[k+1] - gt[k] == 11) n_pass++;
      else $display("FAIL rot_period[%0d] got %0d required 11", k, gt[k+1] - gt[k]);
    end
    wait_drain(40, ok);
    n_chk++;
    if (ok && gq.size() == 5) n_pass++;
    else $display("FAIL rot_drain got pending=%0d grants=%0d required 0 5", sbq.size(), gq.size());
  endtask

  task automatic test_backpressure();
    bit ok;
    int bad;
    logic [7:0] e1;
    bad = 0;
    e1 = exp_cw(5'b01101);
    req_msg[9:5] = 5'b01101;
    req_valid = 4'b0010;
    resp_ready = 1'b0;
    sbq.push_back({2'd1, e1});
    wait_grant(20, ok);
    n_chk++;
    if (ok && req_ready === 4'b0010) n_pass++; else $display("FAIL bp_grant got %b required 0010", req_ready);
    step();
    req_valid = 4'b1000;
    req_msg[19:15] = 5'b11100;
    sbq.push_back({2'd3, exp_cw(5'b11100)});
    for (int i = 0; i < 30 && !resp_valid; i++) step();
    for (int i = 0; i < 20; i++) begin
      if (!(resp_valid === 1'b1 && resp_id === 2'd1 && resp_cw === e1 && req_ready === '0 &&
            crc_enable === 1'b0 && busy === 1'b1)) bad++;
      step();
    end
    n_chk++;
    if (bad == 0) n_pass++; else $display("FAIL bp_hold got %0d unstable cycles required 0", bad);
    resp_ready = 1'b1;
    wait_grant(10, ok);
    n_chk++;
    if (ok && req_ready === 4'b1000) n_pass++; else $display("FAIL bp_next_grant got %b required 1000", req_ready);
    step();
    req_valid = '0;
    wait_drain(40, ok);
    n_chk++;
    if (ok) n_pass++; else $display("FAIL bp_drain got pending=%0d required 0", sbq.size());
  endtask

  task automatic test_stall();
    bit ok, seen;
    int bad;
    bad = 0;
    seen = 1'b0;
    req_msg[4:0] = 5'b11010;
    req_valid = 4'b0001;
    sbq.push_back({2'd0, exp_cw(5'b11010)});
    wait_grant(20, ok);
    step();
    req_valid = '0;
    repeat (3) step();
    ena = 1'b0;
    req_valid = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      step();
      if (!(crc_enable === 1'b1 && crc_data === 1'b1 && busy === 1'b1 && resp_valid === 1'b0 &&
            req_ready === '0 && resp_cw === exp_cw(5'b11100))) bad++;
    end
    n_chk++;
    if (ok && bad == 0) n_pass++; else $display("FAIL stall_frozen got %0d changed cycles required 0", bad);
    req_valid = '0;
    ena = 1'b1;
    wait_drain(40, ok);
    n_chk++;
    if (ok) n_pass++; else $display("FAIL stall_resume got pending=%0d required 0", sbq.size());
    req_msg[9:5] = 5'b01011;
    req_valid = 4'b0010;
    wait_grant(20, ok);
    step();
    req_valid = '0;
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (ok && {req_ready, crc_enable, crc_data, resp_valid, resp_id, resp_cw, err_mismatch, busy} === '0) n_pass++;
    else $display("FAIL midframe_reset got en=%b d=%b rv=%b id=%0d cw=%h busy=%b required all 0",
                  crc_enable, crc_data, resp_valid, resp_id, resp_cw, busy);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (resp_valid || busy) seen = 1'b1;
      step();
    end
    n_chk++;
    if (!seen) n_pass++; else $display("FAIL midframe_no_resp got activity=1 required 0");
  endtask

  task automatic test_mismatch();
    bit ok;
    int bad;
    bad = 0;
    corrupt = 3'b101;
    req_msg[14:10] = 5'b10011;
    req_valid = 4'b0100;
    sbq.push_back({2'd2, exp_cw(5'b10011) ^ 8'h05});
    wait_grant(20, ok);
    step();
    req_valid = '0;
    wait_drain(40, ok);
    n_chk++;
    if (ok && err_mismatch === 1'b1) n_pass++; else $display("FAIL mis_set got %b required 1", err_mismatch);
    for (int i = 0; i < 5; i++) begin
      step();
      if (err_mismatch !== 1'b1) bad++;
    end
    n_chk++;
    if (bad == 0) n_pass++; else $display("FAIL mis_sticky got %0d drops required 0", bad);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    n_chk++;
    if (err_mismatch === 1'b0) n_pass++; else $display("FAIL mis_clear got %b required 0", err_mismatch);
    req_valid = 4'b0100;
    sbq.push_back({2'd2, exp_cw(5'b10011) ^ 8'h05});
    wait_grant(20, ok);
    step();
    req_valid = '0;
    repeat (8) step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    n_chk++;
    if (ok && err_mismatch === 1'b1) n_pass++;
    else $display("FAIL mis_set_wins got %b required 1", err_mismatch);
    corrupt = '0;
    wait_drain(40, ok);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    req_msg[19:15] = 5'b01110;
    req_valid = 4'b1000;
    sbq.push_back({2'd3, exp_cw(5'b01110)});
    wait_grant(20, ok);
    step();
    req_valid = '0;
    wait_drain(40, ok);
    n_chk++;
    if (ok && err_mismatch === 1'b0) n_pass++;
    else $display("FAIL mis_clean_frame got err=%b pending=%0d required 0 0", err_mismatch, sbq.size());
  endtask

  initial begin
    test_reset();
    test_single();
    test_req2();
    test_rotation();
    test_backpressure();
    test_stall();
    test_mismatch();
    repeat (3) step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
